msec_bcd_timer: RTL and testbench
=================================

Name: msec_bcd_timer

Overview:
- Parametrised successor to the single-digit millisecond counter.
- Divides the system clock down to a programmable tick rate and counts ticks in a cascade of NUM_DIGITS modulo-MOD digits (BCD by default).
- Adds enable, synchronous clear, parallel load, up/down direction, wrap or saturate mode, a tick strobe and a terminal-carry strobe.
- Sits between the clock domain and display/sequencing logic as the shared time base.

Parameters:
- CLK_HZ, 4000000, input clock frequency in Hz.
- TICK_HZ, 1000, count rate in Hz. DIV = CLK_HZ/TICK_HZ; DIV must be an integer >= 2, checked at elaboration.
- Q_WIDTH, 4, bits per digit.
- MOD, 10, digit modulus. Requires 2 <= MOD <= 2**Q_WIDTH.
- NUM_DIGITS, 4, number of cascaded digits, >= 1.
- WRAP, 1, terminal behaviour: 1 = wrap around, 0 = saturate.

Ports:
- clk_4m  input  1  system clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  count enable; prescaler and digits hold while low.
- clr  input  1  synchronous clear.
- load  input  1  synchronous parallel load.
- up_dn  input  1  direction: 1 = up, 0 = down.
- load_val  input  NUM_DIGITS*Q_WIDTH  load value; digit 0 in the LSBs.
- Q  output  NUM_DIGITS*Q_WIDTH  count value; digit 0 in the LSBs.
- tick  output  1  one-cycle pulse on each count step.
- carry  output  1  one-cycle pulse on a terminal event.

Behaviour:
- Reset (rst_n low, asynchronous): prescaler = 0, every digit = 0, tick = 0, carry = 0. Release is observed on the next clk_4m edge.
- Priority per edge: clr > load > count.
- clr: prescaler = 0, all digits = 0, tick = 0, carry = 0. Independent of en.
- load: prescaler = 0, digit i = min(load_val digit i, MOD-1), tick = 0, carry = 0. Independent of en.
- Prescaler (en high):
  - pcnt counts 0..DIV-1 and returns to 0.
  - The edge where pcnt == DIV-1 is a step edge: digits update and registered tick = 1 for the following cycle.
  - Step period is exactly DIV cycles.
- en low: pcnt, digits, tick and carry are frozen, except that tick and carry are forced to 0. The prescaler phase is preserved across the pause.
- Up step:
  - Digit 0 increments.
  - A digit at MOD-1 becomes 0 and propagates a carry to the next digit.
  - Propagation is combinational across all digits within the same edge; there is no ripple latency.
- Down step:
  - Digit 0 decrements.
  - A digit at 0 becomes MOD-1 and propagates a borrow to the next digit.
- Terminal state: all digits MOD-1 when counting up; all digits 0 when counting down.
- Step taken from the terminal state:
  - WRAP=1: counter wraps (all 0 going up, all MOD-1 going down); carry = 1 for one cycle, coincident with tick.
  - WRAP=0: digits hold; carry = 1 for one cycle, coincident with tick. Carry re-pulses on every further step while held.
- up_dn may change on any cycle; it is sampled on the step edge only.
- Q is a register output, updated on the step edge; tick and carry are high in the cycle after that edge, i.e. the cycle in which the new Q is first visible.
- Simultaneous events:
  - clr or load on a step edge wins; no step occurs and tick and carry stay 0.
  - en falling on a step edge: the step is suppressed.
- Reset asserted mid-count: immediate return to the reset values, no pulses.

Decomposition:
- Package msec_timer_pkg holds:
  - the localparam function computing DIV;
  - a clog2-based prescaler width helper;
  - the digit typedef logic [Q_WIDTH-1:0].
- Sub-module tick_prescaler (params DIV; ports clk_4m, rst_n, en, clr, tick_pre) generates the step strobe. The top level owns the digit cascade, terminal detection and output registers.

Test Plan (CLK_HZ=8, TICK_HZ=1 so DIV=8; MOD=10, NUM_DIGITS=2, Q_WIDTH=4):
- Reset then en=1, up_dn=1 for 80 cycles -> Q steps every 8 cycles 0x00, 0x01 … 0x09, 0x10; tick is exactly 1 cycle wide every 8 cycles.
- load_val=0x98, then count up with WRAP=1 -> Q goes 0x98, 0x99, 0x00; carry pulses once, coincident with the 0x00 tick.
- Same sequence with WRAP=0 -> Q stays at 0x99; carry pulses on each further tick.
- load_val=0x10, up_dn=0 -> Q goes 0x10, 0x09, 0x08; no carry. From 0x00 down with WRAP=1 -> 0x99 and carry = 1.
- Drop en at pcnt=5 for 20 cycles, then raise it -> the next tick arrives 3 enabled cycles after re-enable; Q is unchanged during the pause.
- clr and load asserted together on a step edge -> Q = 0x00, tick = 0, carry = 0. load_val=0xFC -> Q = 0x99 (clamped). Assert rst_n=0 mid-pcnt -> Q = 0 immediately, asynchronously.

Source files
------------

// File: rtl/msec_timer_pkg.sv
// Shared definitions for the millisecond BCD time base: divider maths and digit type.
package msec_timer_pkg;

   localparam int DEF_Q_WIDTH = 4;

   // Digit type at the default BCD width; the top re-declares it at its own Q_WIDTH.
   typedef logic [DEF_Q_WIDTH-1:0] digit_t;

   function automatic int calc_div(input int clk_hz, input int tick_hz);
      return clk_hz / tick_hz;
   endfunction

   function automatic int pcnt_width(input int div);
      return ($clog2(div) < 1) ? 1 : $clog2(div);
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk_4m by DIV; tick_pre marks the edge on which the counter wraps.
module tick_prescaler
   import msec_timer_pkg::*;
#(
   parameter int DIV = 8
) (
   input  logic clk_4m,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick_pre
);

   localparam int            PW   = pcnt_width(DIV);
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   logic [PW-1:0] pcnt_q;
   logic [PW-1:0] pcnt_d;

   // NOTE: next-state defaults to the held value first, so no path leaves pcnt_d unassigned (no latch).
   always_comb begin
      pcnt_d = pcnt_q;
      if (clr)
         pcnt_d = '0;
      else if (en)
         pcnt_d = (pcnt_q == LAST) ? '0 : pcnt_q + PW'(1);
   end

   assign tick_pre = en & ~clr & (pcnt_q == LAST);

   // NOTE: non-blocking assignment keeps every register sampling pre-edge values.
   always_ff @(posedge clk_4m or negedge rst_n) begin
      if (!rst_n)
         pcnt_q <= '0;
      else
         pcnt_q <= pcnt_d;
   end

endmodule

// File: rtl/msec_bcd_timer.sv
// Programmable-rate time base: a cascade of modulo-MOD digits stepped by a clock prescaler.
module msec_bcd_timer
   import msec_timer_pkg::*;
#(
   parameter int CLK_HZ     = 4000000,
   parameter int TICK_HZ    = 1000,
   parameter int Q_WIDTH    = 4,
   parameter int MOD        = 10,
   parameter int NUM_DIGITS = 4,
   parameter int WRAP       = 1
) (
   input  logic                          clk_4m,
   input  logic                          rst_n,
   input  logic                          en,
   input  logic                          clr,
   input  logic                          load,
   input  logic                          up_dn,
   input  logic [NUM_DIGITS*Q_WIDTH-1:0] load_val,
   output logic [NUM_DIGITS*Q_WIDTH-1:0] Q,
   output logic                          tick,
   output logic                          carry
);

   localparam int DIV = calc_div(CLK_HZ, TICK_HZ);

   typedef logic [Q_WIDTH-1:0] dig_t;
   localparam dig_t DMAX = dig_t'(MOD - 1);

   if (TICK_HZ < 1 || (CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
      $error("CLK_HZ/TICK_HZ must be an integer >= 2");
   end
   if (MOD < 2 || MOD > (2 ** Q_WIDTH)) begin : g_bad_mod
      $error("MOD must lie in 2..2**Q_WIDTH");
   end
   if (NUM_DIGITS < 1) begin : g_bad_digits
      $error("NUM_DIGITS must be >= 1");
   end

   logic step;
   logic terminal;
   logic tick_q;
   logic carry_q;
   dig_t digit_q    [NUM_DIGITS];
   dig_t digit_step [NUM_DIGITS];
   dig_t digit_load [NUM_DIGITS];

   // clr and load both restart the prescaler and also veto a coincident step.
   tick_prescaler #(.DIV(DIV)) u_prescaler (
      .clk_4m   (clk_4m),
      .rst_n    (rst_n),
      .en       (en),
      .clr      (clr | load),
      .tick_pre (step)
   );

   // Carry/borrow ripples combinationally; surviving the last digit means terminal state.
   always_comb begin
      logic chain;
      chain = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         digit_step[i] = digit_q[i];
         if (chain) begin
            if (up_dn) begin
               if (digit_q[i] == DMAX) begin
                  digit_step[i] = '0;
               end else begin
                  digit_step[i] = digit_q[i] + dig_t'(1);
                  chain         = 1'b0;
               end
            end else begin
               if (digit_q[i] == '0) begin
                  digit_step[i] = DMAX;
               end else begin
                  digit_step[i] = digit_q[i] - dig_t'(1);
                  chain         = 1'b0;
               end
            end
         end
      end
      terminal = chain;
   end

   always_comb begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
         digit_load[i] = load_val[i*Q_WIDTH +: Q_WIDTH];
         if (digit_load[i] > DMAX)
            digit_load[i] = DMAX;
      end
   end

   always_ff @(posedge clk_4m or negedge rst_n) begin
      if (!rst_n) begin
         digit_q <= '{default: '0};
         tick_q  <= 1'b0;
         carry_q <= 1'b0;
      end else begin
         tick_q  <= 1'b0;
         carry_q <= 1'b0;
         if (clr) begin
            digit_q <= '{default: '0};
         end else if (load) begin
            digit_q <= digit_load;
         end else if (step) begin
            if (WRAP != 0 || !terminal)
               digit_q <= digit_step;
            tick_q  <= 1'b1;
            carry_q <= terminal;
         end
      end
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_q
      assign Q[g*Q_WIDTH +: Q_WIDTH] = digit_q[g];
   end

   assign tick  = tick_q;
   assign carry = carry_q;

endmodule

// File: tb/tb_msec_bcd_timer.sv
// Directed bench: a wrapping and a saturating instance share stimulus, DIV=8, two BCD digits.
module tb_msec_bcd_timer;

   logic       clk_4m;
   logic       rst_n;
   logic       en;
   logic       clr;
   logic       load;
   logic       up_dn;
   logic [7:0] load_val;
   logic [7:0] q_w, q_s;
   logic       tick_w, tick_s, carry_w, carry_s;

   int n_checks = 0;
   int n_pass   = 0;

   msec_bcd_timer #(
      .CLK_HZ(8), .TICK_HZ(1), .Q_WIDTH(4), .MOD(10), .NUM_DIGITS(2), .WRAP(1)
   ) dut (
      .clk_4m(clk_4m), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .up_dn(up_dn),
      .load_val(load_val), .Q(q_w), .tick(tick_w), .carry(carry_w)
   );

   msec_bcd_timer #(
      .CLK_HZ(8), .TICK_HZ(1), .Q_WIDTH(4), .MOD(10), .NUM_DIGITS(2), .WRAP(0)
   ) dut_sat (
      .clk_4m(clk_4m), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .up_dn(up_dn),
      .load_val(load_val), .Q(q_s), .tick(tick_s), .carry(carry_s)
   );

   initial begin
      clk_4m = 1'b0;
      forever #5 clk_4m = ~clk_4m;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
   endtask

   task automatic step();
      @(posedge clk_4m);
      #1;
   endtask

   task automatic do_load(input logic [7:0] val);
      load_val = val;
      load     = 1'b1;
      step();
      load     = 1'b0;
   endtask

   // Advances until tick is seen and checks how many cycles that took.
   task automatic wait_tick(input int exp_cyc, input string tag);
      int  n    = 0;
      bit  seen = 1'b0;
      while (!seen && n < 40) begin
         step();
         n++;
         if (tick_w) seen = 1'b1;
      end
      check(tag, n, exp_cyc);
   endtask

   initial begin
      logic [7:0] exp_q;
      rst_n    = 1'b0;
      en       = 1'b0;
      clr      = 1'b0;
      load     = 1'b0;
      up_dn    = 1'b1;
      load_val = 8'h00;
      repeat (2) step();
      check("rst_q",     q_w,     8'h00);
      check("rst_tick",  tick_w,  1'b0);
      check("rst_carry", carry_w, 1'b0);

      rst_n = 1'b1;
      en    = 1'b1;
      for (int k = 1; k <= 80; k++) begin
         step();
         check("up_tick", tick_w, (k % 8 == 0));
         if (k % 8 == 0) begin
            exp_q = {4'((k / 8) / 10), 4'((k / 8) % 10)};
            check("up_q", q_w, exp_q);
         end
      end

      do_load(8'h98);
      check("ld98_w", q_w, 8'h98);
      check("ld98_s", q_s, 8'h98);
      wait_tick(8, "per_99");
      check("q99_w", q_w, 8'h99);
      check("c99_w", carry_w, 1'b0);
      wait_tick(8, "per_wrap");
      check("wrap_q",   q_w,     8'h00);
      check("wrap_c",   carry_w, 1'b1);
      check("sat_q",    q_s,     8'h99);
      check("sat_c",    carry_s, 1'b1);
      check("sat_tick", tick_s,  1'b1);
      step();
      check("c_width", carry_w, 1'b0);
      check("t_width", tick_w,  1'b0);
      wait_tick(7, "per_after");
      check("wrap_q2", q_w,     8'h01);
      check("wrap_c2", carry_w, 1'b0);
      check("sat_q2",  q_s,     8'h99);
      check("sat_c2",  carry_s, 1'b1);

      up_dn = 1'b0;
      do_load(8'h10);
      check("ld10", q_w, 8'h10);
      wait_tick(8, "per_dn1");
      check("dn_q1", q_w,     8'h09);
      check("dn_c1", carry_w, 1'b0);
      wait_tick(8, "per_dn2");
      check("dn_q2", q_w,     8'h08);
      check("dn_c2", carry_w, 1'b0);
      do_load(8'h00);
      wait_tick(8, "per_dn0");
      check("dnwrap_q", q_w,     8'h99);
      check("dnwrap_c", carry_w, 1'b1);
      check("dnsat_q",  q_s,     8'h00);
      check("dnsat_c",  carry_s, 1'b1);

      up_dn = 1'b1;
      do_load(8'h00);
      repeat (5) step();
      en = 1'b0;
      repeat (20) begin
         step();
         check("pause_tick", tick_w, 1'b0);
      end
      check("pause_q", q_w, 8'h00);
      en = 1'b1;
      wait_tick(3, "resume_cyc");
      check("resume_q", q_w, 8'h01);

      repeat (7) step();
      clr      = 1'b1;
      load     = 1'b1;
      load_val = 8'h55;
      step();
      clr  = 1'b0;
      load = 1'b0;
      check("clr_q",     q_w,     8'h00);
      check("clr_tick",  tick_w,  1'b0);
      check("clr_carry", carry_w, 1'b0);
      wait_tick(8, "per_clr");
      check("clr_next", q_w, 8'h01);

      do_load(8'hFC);
      check("clamp_fc", q_w, 8'h99);
      do_load(8'hA3);
      check("clamp_a3", q_w, 8'h93);

      repeat (3) step();
      rst_n = 1'b0;
      #1;
      check("arst_q_w", q_w,    8'h00);
      check("arst_q_s", q_s,    8'h00);
      check("arst_tick", tick_w, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
